// File: rtl/fixedp_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fixedp_mac_pipe
//  Purpose  : Pipelined sign-magnitude fixed-point multiply-accumulate.
//             Operand pairs stream in over a valid/ready handshake. Each
//             group of products, terminated by in_last, is summed in a
//             two's-complement accumulator with guard bits. One saturated
//             sign-magnitude result is emitted per group, together with a
//             flag that reports whether any saturation happened in the group.
//
//  Pipeline : S1 multiply (|a|*|b|, Q slice, product saturation)
//             S2 accumulate (clamped add; on the last beat, convert to
//                sign-magnitude and register the result)
//             The result is valid 2 cycles after the in_last beat is accepted.
//
//  Parameters
//    N          total word width (bit N-1 = sign, N-2:0 = magnitude)
//    Q          fractional bits, 1 <= Q <= N-2
//    ACC_GUARD  extra integer bits in the internal accumulator
//
//  Ports
//    clk        in   1   clock, rising edge
//    rst        in   1   asynchronous reset, active high
//    in_valid   in   1   operand pair valid
//    in_ready   out  1   operand pair accepted this cycle
//    in_a       in   N   operand A, sign-magnitude Q format
//    in_b       in   N   operand B, sign-magnitude Q format
//    in_last    in   1   final pair of the current group
//    out_valid  out  1   result valid
//    out_ready  in   1   downstream accepts the result
//    out_sum    out  N   group sum, sign-magnitude Q format
//    out_sat    out  1   saturation occurred somewhere in this group
//
//  Build option
//    FIXEDP_MAC_ROUND_EN  defined: round the product magnitude half up
//                         before the Q slice. Undefined: truncate.
//
//  Revision : 1.0  initial release
// ============================================================================
module fixedp_mac_pipe #(
    parameter int N         = 32,
    parameter int Q         = 15,
    parameter int ACC_GUARD = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_sat
);

    localparam int AW = N + ACC_GUARD;   // accumulator width
    localparam int MW = 2 * N - 2;       // full product magnitude width

    // Accumulator clamp limits; symmetric so that negation never overflows.
    localparam logic [AW-1:0] c_acc_pos = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] c_acc_neg = {1'b1, {(AW-2){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Flow control: the whole pipeline advances unless a result is held.
    // ------------------------------------------------------------------
    logic w_adv;
    assign w_adv    = ~(out_valid & ~out_ready);
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // S1 combinational: magnitude product, Q slice, product saturation
    // ------------------------------------------------------------------
    logic [MW-1:0]  w_mag;
    logic [MW-1:0]  w_mag_r;
    logic           w_ovf;
    logic [N-2:0]   w_p;
    logic           w_sign;
    logic [Q-1:0]   w_unused_lsbs;

    assign w_mag = {{(N-1){1'b0}}, in_a[N-2:0]} * {{(N-1){1'b0}}, in_b[N-2:0]};

`ifdef FIXEDP_MAC_ROUND_EN
    // Half-LSB added on the magnitude, so rounding is symmetric about zero.
    // The sum cannot overflow MW bits because Q <= N-2.
    localparam logic [MW-1:0] c_round = {{(MW-1){1'b0}}, 1'b1} << (Q - 1);
    assign w_mag_r = w_mag + c_round;
`else
    assign w_mag_r = w_mag;
`endif

    assign w_unused_lsbs = w_mag_r[Q-1:0];
    assign w_ovf         = |w_mag_r[MW-1:N-1+Q];
    assign w_p           = w_ovf ? {(N-1){1'b1}} : w_mag_r[N-2+Q:Q];
    // A zero magnitude is always carried as +0.
    assign w_sign        = (in_a[N-1] ^ in_b[N-1]) & (w_p != '0);

    // ------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------
    logic           r_s1_valid;
    logic           r_s1_last;
    logic           r_s1_sign;
    logic [N-2:0]   r_s1_mag;
    logic           r_s1_flag;

    // ------------------------------------------------------------------
    // S2 combinational: clamped accumulate and sign-magnitude conversion
    // ------------------------------------------------------------------
    logic [AW-1:0]  r_acc;
    logic           r_grp_flag;
    logic           r_out_valid;
    logic [N-1:0]   r_out_sum;
    logic           r_out_sat;

    logic [AW:0]    w_p_ext;
    logic [AW:0]    w_p_signed;
    logic [AW:0]    w_acc_ext;
    logic [AW:0]    w_sum;
    logic           w_acc_hi;
    logic           w_acc_lo;
    logic [AW-1:0]  w_acc_next;
    logic           w_beat_flag;
    logic           w_res_neg;
    logic [AW-1:0]  w_res_abs;
    logic           w_res_big;
    logic [N-2:0]   w_res_mag;
    logic           w_res_sign;
    logic           w_grp_sat;
    logic           w_emit;

    // One extra bit of headroom: |p| < 2^(N-1) so the add never wraps here.
    assign w_p_ext    = {{(ACC_GUARD+2){1'b0}}, r_s1_mag};
    assign w_p_signed = r_s1_sign ? (~w_p_ext + 1'b1) : w_p_ext;
    assign w_acc_ext  = {r_acc[AW-1], r_acc};
    assign w_sum      = w_acc_ext + w_p_signed;

    assign w_acc_hi   = $signed(w_sum) > $signed({c_acc_pos[AW-1], c_acc_pos});
    assign w_acc_lo   = $signed(w_sum) < $signed({c_acc_neg[AW-1], c_acc_neg});
    assign w_acc_next = w_acc_hi ? c_acc_pos :
                        w_acc_lo ? c_acc_neg : w_sum[AW-1:0];

    assign w_beat_flag = r_s1_flag | w_acc_hi | w_acc_lo;

    // The clamp keeps the accumulator away from -2^(AW-1), so the
    // two's-complement negation below is always exact.
    assign w_res_neg  = w_acc_next[AW-1];
    assign w_res_abs  = w_res_neg ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_res_big  = |w_res_abs[AW-1:N-1];
    assign w_res_mag  = w_res_big ? {(N-1){1'b1}} : w_res_abs[N-2:0];
    assign w_res_sign = w_res_neg & (w_res_mag != '0);

    assign w_grp_sat  = r_grp_flag | w_beat_flag | w_res_big;
    assign w_emit     = r_s1_valid & r_s1_last;

    // ------------------------------------------------------------------
    // Sequential state. Everything updates only when the pipeline advances,
    // which keeps out_sum/out_sat stable while a result is held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_mag    <= '0;
            r_s1_flag   <= 1'b0;
            r_acc       <= '0;
            r_grp_flag  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_last <= in_last;
                r_s1_sign <= w_sign;
                r_s1_mag  <= w_p;
                r_s1_flag <= w_ovf;
            end

            // When advancing, any previous result is either absent or being
            // taken this cycle, so a new result simply replaces it.
            r_out_valid <= w_emit;

            if (r_s1_valid) begin
                if (r_s1_last) begin
                    r_out_sum  <= {w_res_sign, w_res_mag};
                    r_out_sat  <= w_grp_sat;
                    // Clearing here makes the next beat the start of a new group.
                    r_acc      <= '0;
                    r_grp_flag <= 1'b0;
                end else begin
                    r_acc      <= w_acc_next;
                    r_grp_flag <= r_grp_flag | w_beat_flag;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_fixedp_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fixedp_mac_pipe
//  Purpose  : Directed self-checking bench for fixedp_mac_pipe (N=32, Q=15).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fixedp_mac_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_sat;

    fixedp_mac_pipe #(.N(32), .Q(15), .ACC_GUARD(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Results are {sat, sum}.
    logic [32:0] obs_q[$];
    int          obs_cyc[$];
    logic [32:0] exp_q[$];

    // Capture every result that is handed over at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back({out_sat, out_sum});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Present one beat and return just after the edge that accepts it.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        int t;
        t        = 0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 33'd0, 33'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_res(input logic sat, input logic [31:0] sum);
        exp_q.push_back({sat, sum});
    endtask

    task automatic wait_obs(input int n);
        int t;
        t = 0;
        while (obs_q.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic drain(input string tag);
        wait_obs(exp_q.size());
        @(negedge clk);
        while (exp_q.size() > 0) begin
            if (obs_q.size() == 0) begin
                check({tag, "_missing"}, 33'd0, exp_q.pop_front());
            end else begin
                check(tag, obs_q.pop_front(), exp_q.pop_front());
            end
        end
        check({tag, "_extra"}, 33'(obs_q.size()), 33'd0);
        obs_q.delete();
        obs_cyc.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 33'(out_valid), 33'd0);
        check("rst_out_sum",   33'(out_sum),   33'd0);
        check("rst_out_sat",   33'(out_sat),   33'd0);
        check("rst_in_ready",  33'(in_ready),  33'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1-beat group 1.0*2.0, with latency check.
        send(32'h0000_8000, 32'h0001_0000, 1'b1);
        check("lat_cycle1", 33'(out_valid), 33'd0);
        @(posedge clk);
        #1;
        check("lat_cycle2_valid", 33'(out_valid), 33'd1);
        check("lat_cycle2_sum",   33'(out_sum),   33'h0_0001_0000);
        expect_res(1'b0, 32'h0001_0000);
        drain("single");

        // +2.0 then -1.0 -> +1.0 ; +1.0*-1.0 alone -> -1.0
        send(32'h0000_8000, 32'h0001_0000, 1'b0);
        send(32'h8000_8000, 32'h0000_8000, 1'b1);
        send(32'h0000_8000, 32'h8000_8000, 1'b1);
        expect_res(1'b0, 32'h0000_8000);
        expect_res(1'b0, 32'h8000_8000);
        drain("accum");

        // Product saturation, then flags clear for the next group.
        send(32'h4000_0000, 32'h4000_0000, 1'b1);
        send(32'h0000_8000, 32'h0000_8000, 1'b1);
        expect_res(1'b1, 32'h7FFF_FFFF);
        expect_res(1'b0, 32'h0000_8000);
        drain("prod_sat");

        // Output-range saturation from the accumulated sum, both signs.
        send(32'h4000_0000, 32'h0000_8000, 1'b0);
        send(32'h4000_0000, 32'h0000_8000, 1'b1);
        send(32'hC000_0000, 32'h0000_8000, 1'b0);
        send(32'hC000_0000, 32'h0000_8000, 1'b1);
        expect_res(1'b1, 32'h7FFF_FFFF);
        expect_res(1'b1, 32'hFFFF_FFFF);
        drain("sum_sat");

        // +1.0 + -1.0 must come out as +0.
        send(32'h0000_8000, 32'h0000_8000, 1'b0);
        send(32'h8000_8000, 32'h0000_8000, 1'b1);
        expect_res(1'b0, 32'h0000_0000);
        drain("neg_zero");

        // Smallest LSB times 0.5: rounding decides the answer.
        send(32'h0000_0001, 32'h0000_4000, 1'b1);
`ifdef FIXEDP_MAC_ROUND_EN
        expect_res(1'b0, 32'h0000_0001);
`else
        expect_res(1'b0, 32'h0000_0000);
`endif
        drain("round");

        // Back-to-back 1-beat groups emerge on consecutive cycles.
        send(32'h0000_8000, 32'h0000_8000, 1'b1);
        send(32'h0001_0000, 32'h0000_8000, 1'b1);
        send(32'h0001_8000, 32'h0000_8000, 1'b1);
        wait_obs(3);
        if (obs_cyc.size() >= 3) begin
            check("b2b_gap0", 33'(obs_cyc[1] - obs_cyc[0]), 33'd1);
            check("b2b_gap1", 33'(obs_cyc[2] - obs_cyc[1]), 33'd1);
        end else begin
            check("b2b_count", 33'(obs_cyc.size()), 33'd3);
        end
        expect_res(1'b0, 32'h0000_8000);
        expect_res(1'b0, 32'h0001_0000);
        expect_res(1'b0, 32'h0001_8000);
        drain("b2b");

        // Back-pressure: hold the first result for 5 cycles.
        out_ready = 1'b0;
        fork
            begin
                send(32'h0000_8000, 32'h0000_8000, 1'b1);
                send(32'h0000_8000, 32'h0001_0000, 1'b0);
                send(32'h0000_8000, 32'h0000_8000, 1'b1);
                send(32'h0001_0000, 32'h0001_0000, 1'b1);
                send(32'h8000_8000, 32'h0000_8000, 1'b1);
            end
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                check("bp_valid",      33'(out_valid), 33'd1);
                check("bp_ready_low",  33'(in_ready),  33'd0);
                check("bp_sum_first",  33'(out_sum),   33'h0_0000_8000);
                repeat (5) @(negedge clk);
                check("bp_sum_stable", 33'(out_sum),   33'h0_0000_8000);
                check("bp_still_held", 33'(in_ready),  33'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        expect_res(1'b0, 32'h0000_8000);
        expect_res(1'b0, 32'h0001_8000);
        expect_res(1'b0, 32'h0002_0000);
        expect_res(1'b0, 32'h8000_8000);
        drain("backpressure");

        // Asynchronous reset clears a held result immediately.
        out_ready = 1'b0;
        send(32'h0000_8000, 32'h0000_8000, 1'b1);
        @(posedge clk);
        #1;
        check("rst_held_before", 33'(out_valid), 33'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 33'(out_valid), 33'd0);
        check("rst_async_sum",   33'(out_sum),   33'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a group discards the partial sum.
        send(32'h0000_8000, 32'h0000_8000, 1'b0);
        send(32'h0000_8000, 32'h0000_8000, 1'b0);
        send(32'h0000_8000, 32'h0000_8000, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h0000_8000, 32'h0000_8000, 1'b1);
        expect_res(1'b0, 32'h0000_8000);
        drain("rst_midgroup");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
